// File: rtl/alu_op_arbiter.sv
// ============================================================================
// alu_op_arbiter: round-robin sharing of one multi-cycle ALU among NREQ requesters.
// Optional macro ALU_ARB_ILLEGAL_OPR_EN adds the err port.  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_op_arbiter #(
   parameter int NREQ = 4,
   parameter int OPW  = 4,
   parameter int DW   = 16,
   parameter int CW   = 6
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [NREQ-1:0]      req,
   input  logic [NREQ*OPW-1:0]  opr_in,
   output logic [NREQ-1:0]      gnt,
   output logic                 exec_start,
   output logic [OPW-1:0]       exec_opr,
   input  logic [DW-1:0]        exec_result,
   output logic [DW-1:0]        result_out,
   output logic [NREQ-1:0]      done,
`ifdef ALU_ARB_ILLEGAL_OPR_EN
   output logic                 err,
`endif
   output logic                 busy
);

   localparam int              IW       = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [IW-1:0]   LAST_IDX = IW'(NREQ - 1);
   localparam logic [NREQ-1:0] ONE_HOT0 = NREQ'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t          state;
   state_t          state_nxt;
   logic [IW-1:0]   rr_ptr;
   logic [IW-1:0]   owner;
   logic [IW-1:0]   win_idx;
   logic [IW-1:0]   cand;
   logic            win_found;
   logic [OPW-1:0]  win_opr;
   logic [CW-1:0]   cnt;

   // Unlisted opcodes fall through to a single-cycle latency.
   function automatic logic [CW-1:0] op_latency(input logic [OPW-1:0] op);
      case (op)
         OPW'(2), OPW'(3):  op_latency = CW'(2);
         OPW'(4):           op_latency = CW'(6);
         OPW'(6):           op_latency = CW'(4);
         OPW'(9), OPW'(10): op_latency = CW'(38);
         default:           op_latency = CW'(1);
      endcase
   endfunction

`ifdef ALU_ARB_ILLEGAL_OPR_EN
   function automatic logic op_supported(input logic [OPW-1:0] op);
      case (op)
         OPW'(0), OPW'(1), OPW'(2), OPW'(3), OPW'(4),
         OPW'(6), OPW'(8), OPW'(9), OPW'(10): op_supported = 1'b1;
         default:                             op_supported = 1'b0;
      endcase
   endfunction
`endif

   // First active request at or after the rotating pointer, wrapping at NREQ.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int k = 0; k < NREQ; k++) begin
         cand = IW'((int'(rr_ptr) + k) % NREQ);
         if (!win_found && req[cand]) begin
            win_found = 1'b1;
            win_idx   = cand;
         end
      end
   end

   always_comb begin
      win_opr = '0;
      for (int k = 0; k < NREQ; k++) begin
         if (IW'(k) == win_idx) begin
            win_opr = opr_in[k*OPW +: OPW];
         end
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = state;
      gnt        = '0;
      done       = '0;
      exec_start = 1'b0;
      busy       = (state != ST_IDLE);
`ifdef ALU_ARB_ILLEGAL_OPR_EN
      err        = 1'b0;
`endif
      case (state)
         ST_IDLE: begin
            if (win_found) begin
               state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            gnt = ONE_HOT0 << owner;
`ifdef ALU_ARB_ILLEGAL_OPR_EN
            if (op_supported(exec_opr)) begin
               exec_start = 1'b1;
               state_nxt  = ST_WAIT;
            end else begin
               state_nxt  = ST_DONE;
            end
`else
            exec_start = 1'b1;
            state_nxt  = ST_WAIT;
`endif
         end
         ST_WAIT: begin
            if (cnt == CW'(1)) begin
               state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            done = ONE_HOT0 << owner;
`ifdef ALU_ARB_ILLEGAL_OPR_EN
            err  = !op_supported(exec_opr);
`endif
            state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // exec_opr stays frozen from the grant onwards, so later opr_in changes are ignored.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         rr_ptr     <= '0;
         owner      <= '0;
         exec_opr   <= '0;
         cnt        <= '0;
         result_out <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (win_found) begin
                  owner    <= win_idx;
                  exec_opr <= win_opr;
               end
            end
            ST_ISSUE: begin
               cnt <= op_latency(exec_opr);
            end
            ST_WAIT: begin
               cnt <= cnt - CW'(1);
               if (cnt == CW'(1)) begin
                  result_out <= exec_result;
               end
            end
            ST_DONE: begin
               rr_ptr <= (owner == LAST_IDX) ? '0 : owner + IW'(1);
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_alu_op_arbiter.sv
// ============================================================================
// tb_alu_op_arbiter: directed self-checking bench for alu_op_arbiter.  Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_op_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] opr_in = '0;
   logic [3:0]  gnt;
   logic        exec_start;
   logic [3:0]  exec_opr;
   logic [15:0] exec_result = '0;
   logic [15:0] result_out;
   logic [3:0]  done;
   logic        busy;
`ifdef ALU_ARB_ILLEGAL_OPR_EN
   logic        err;
`endif

   int cyc     = 0;
   int n_total = 0;
   int n_pass  = 0;

   alu_op_arbiter #(.NREQ(4), .OPW(4), .DW(16), .CW(6)) dut (
      .clock       (clk),
      .reset       (rst_n),
      .req         (req),
      .opr_in      (opr_in),
      .gnt         (gnt),
      .exec_start  (exec_start),
      .exec_opr    (exec_opr),
      .exec_result (exec_result),
      .result_out  (result_out),
      .done        (done),
`ifdef ALU_ARB_ILLEGAL_OPR_EN
      .err         (err),
`endif
      .busy        (busy)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // exec_result changes every cycle so a capture in the wrong cycle is visible.
   task automatic tick();
      @(posedge clk);
      #1;
      cyc++;
      exec_result = 16'h5A00 + 16'(cyc);
   endtask

   task automatic wait_gnt(output int n);
      n = 0;
      while (gnt == '0 && n < 60) begin
         tick();
         n++;
      end
   endtask

   task automatic do_op(input int who, input logic [3:0] op, input int lat,
                        input bit drop, input string tag, output int t_gnt);
      int n;
      bit bad;
      wait_gnt(n);
      t_gnt = cyc;
      check({tag, ":gnt"},   32'(gnt),        32'(1) << who);
      check({tag, ":start"}, 32'(exec_start), 32'd1);
      check({tag, ":opr"},   32'(exec_opr),   32'(op));
      bad = 1'b0;
      for (int i = 0; i < lat; i++) begin
         tick();
         if (drop && i == 0) req[who] = 1'b0;
         if (done != '0 || gnt != '0 || exec_start || !busy || exec_opr != op) bad = 1'b1;
      end
      check({tag, ":wait"},   32'(bad),        32'd0);
      tick();
      check({tag, ":done"},   32'(done),       32'(1) << who);
      check({tag, ":busy"},   32'(busy),       32'd1);
      check({tag, ":result"}, 32'(result_out), 32'(16'h5A00 + 16'(t_gnt + lat)));
      tick();
      check({tag, ":idle"},   32'({busy, done}), 32'd0);
   endtask

   initial begin
      int tg;
      int prev;
      int n;
      bit bad;

      // Reset state
      tick();
      tick();
      check("rst_ctl",    32'({gnt, done, exec_start, busy}), 32'd0);
      check("rst_opr",    32'(exec_opr),   32'd0);
      check("rst_result", 32'(result_out), 32'd0);
      rst_n = 1'b1;

      // All requesters at once: strict rotation with wrap, LAT=1 spacing of 4
      opr_in = 16'h0000;
      req    = 4'b1111;
      prev   = 0;
      for (int i = 0; i < 5; i++) begin
         do_op(i % 4, 4'h0, 1, 1'b0, $sformatf("rot%0d", i), tg);
         if (i > 0) check($sformatf("rot%0d:space", i), 32'(tg - prev), 32'd4);
         prev = tg;
      end
      req = 4'b0000;

      // Reset in the middle of a 38-cycle op; pointer returns to requester 0
      opr_in = 16'h00A0;
      req    = 4'b0010;
      wait_gnt(n);
      check("mid_rst:gnt", 32'(gnt), 32'b0010);
      for (int i = 0; i < 10; i++) begin
         tick();
         if (i == 0) req = 4'b0000;
      end
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst:ctl",    32'({gnt, done, exec_start, busy}), 32'd0);
      check("mid_rst:opr",    32'(exec_opr),   32'd0);
      check("mid_rst:result", 32'(result_out), 32'd0);
      bad = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (done != '0 || busy) bad = 1'b1;
      end
      check("mid_rst:no_done", 32'(bad), 32'd0);
      rst_n  = 1'b1;
      opr_in = 16'h0000;
      req    = 4'b0011;
      do_op(0, 4'h0, 1, 1'b1, "post_rst0", tg);
      do_op(1, 4'h0, 1, 1'b1, "post_rst1", tg);

      // Requester 0, opcode 0100 (LAT 6); opr_in change after grant is ignored
      opr_in = 16'h0004;
      req    = 4'b0001;
      wait_gnt(n);
      opr_in = 16'h0009;
      do_op(0, 4'h4, 6, 1'b1, "lat6", tg);
      opr_in = 16'h0000;

      // Requester 2, opcode 1001 (LAT 38)
      opr_in = 16'h0900;
      req    = 4'b0100;
      do_op(2, 4'h9, 38, 1'b1, "lat38", tg);

      // Requester 3 drops req after grant, opcode 0110 (LAT 4)
      opr_in = 16'h6000;
      req    = 4'b1000;
      do_op(3, 4'h6, 4, 1'b1, "drop", tg);
      bad = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (gnt != '0 || busy) bad = 1'b1;
      end
      check("drop:no_regrant", 32'(bad), 32'd0);

      // Unsupported opcode 0111
      opr_in = 16'h0007;
      req    = 4'b0001;
`ifdef ALU_ARB_ILLEGAL_OPR_EN
      prev = 32'(result_out);
      wait_gnt(n);
      check("illegal:gnt",   32'(gnt),        32'b0001);
      check("illegal:start", 32'(exec_start), 32'd0);
      req = 4'b0000;
      tick();
      check("illegal:done",   32'(done),       32'b0001);
      check("illegal:err",    32'(err),        32'd1);
      check("illegal:result", 32'(result_out), 32'(prev));
      tick();
`else
      do_op(0, 4'h7, 1, 1'b1, "illegal", tg);
`endif
      req = 4'b0000;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

`default_nettype wire
